bcd_mul_seq: RTL and testbench
==============================

# bcd_mul_seq

Digit-serial N-digit packed-BCD multiplier controller. It accepts two unsigned N-digit BCD operands through a valid/ready handshake and produces the 2N-digit product over N iterations. Each iteration uses one row multiply (operand A × one digit of B) and one BCD accumulate, which replaces the fully combinational recursive multiplier tree where area matters more than latency. It sits in the decimal FPU between operand unpacking and normalisation/rounding.

## Interface
- N, 16: operand width in BCD digits; legal range 2..32.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands a/b are valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  N*4  multiplicand, packed BCD, digit 0 in bits [3:0].
- b  in  N*4  multiplier, packed BCD.
- out_valid  out  1  product is valid; held until accepted.
- out_ready  in  1  consumer accepts the product.
- p  out  2N*4  product, packed BCD.
- inv  out  1  at least one nibble of a or b was greater than 9; qualified by out_valid.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. A handshake (in_valid & in_ready) latches a into areg and b into breg, clears the accumulator P (2N digits), clears cnt, computes and latches the inv flag, and moves to BUSY.
- BUSY, one step per cycle, where d = breg digit 0:
  - row = areg × d gives N+1 digits.
  - The upper N+1 digits of P become {carry, P[2N-1:N]} + row, a BCD add whose result cannot exceed N+1 digits.
  - P then shifts right one digit. Digit 0 of P is discarded into the finished low product and the new sum occupies the top.
  - breg shifts right one digit. cnt increments.
  - When cnt = N-1, go to DONE.
- Zero digits of b still take one cycle, so latency is fixed.
- DONE: out_valid=1 and p = P. If inv is set, p is forced to 0. When out_ready=1, go to IDLE.
- in_ready is 0 in BUSY and in DONE. Operands are not accepted in the same cycle as product acceptance.
- rst in any state: go to IDLE and clear P, areg, breg, cnt and inv. No partial product is ever presented.
- in_valid during BUSY or DONE is ignored, and the upstream block holds its operands.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, p=0, inv=0.
- If the accept edge is T, the BUSY steps occur at edges T+1..T+N and out_valid rises after edge T+N.
- Latency from acceptance to out_valid is N cycles.
- Minimum throughput is one product per N+2 cycles (accept, N steps, drain/return to IDLE).
- p and inv are stable for the whole time out_valid is high.
- out_valid falls on the edge after out_valid & out_ready, and in_ready rises on that same edge.
- cnt is $clog2(N) bits wide. The wrap at N-1 is explicit, so the counter never wraps naturally.

## Structure
- Shared package bcd_pkg holds:
  - the state enum (IDLE, BUSY, DONE);
  - the digit type (4-bit);
  - the constant BCD_MAX_DIGIT = 9.
- One sub-module: bcd_row_mul, a combinational N-digit × 1-digit → N+1 digit multiplier. It is built from per-digit lookup products, with the low and high product digits summed through a ripple BCD digit adder.
- The accumulate adder uses the existing ripple BCD N-digit adder at width N+1.
- Nibble validity checks (>9) are a simple reduction in the top level.

## Test plan
Use N=4 unless stated otherwise.
- After reset with in_valid=0: in_ready=1, out_valid=0, p=0, and the outputs stay that way for 10 cycles.
- a=0x1234, b=0x5678: out_valid is high exactly 4 cycles after the accept edge, p=0x07006652, inv=0.
- a=0x9999, b=0x9999: p=0x99980001. Then a=0x0000, b=0x9999 gives p=0x00000000. Then a=0x0025, b=0x0018 gives p=0x00000450.
- Backpressure: hold out_ready=0 for 7 cycles after out_valid. p stays 0x07006652, in_ready stays 0, and a new in_valid is ignored. Release out_ready, and in_ready=1 on the next cycle.
- Invalid nibble: a=0x12A4, b=0x0002 gives inv=1 and p=0 after 4 cycles. A following valid operation gives inv=0.
- Reset mid-operation: assert rst at step 2 of a=0x9999, b=0x9999. Next cycle shows IDLE, out_valid=0, p=0. A new a=0x0003, b=0x0007 then gives p=0x00000021. Repeat with N=16 for a=b=10^16-1, giving p = 9 (×15), 8, 0 (×15), 1.

Source files
------------

// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared types and helpers for the digit-serial packed-BCD multiplier.
//   state_e        : controller states (IDLE, BUSY, DONE)
//   digit_t        : one packed-BCD digit (4 bits)
//   BCD_MAX_DIGIT  : largest legal BCD nibble value
//   bcd_digit_add  : one-digit BCD add with carry in/out -> {cout, digit}
//   digit_mul      : one-digit x one-digit product split into {hi, lo} digits
// ---------------------------------------------------------------------------
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_e;

   typedef logic [3:0] digit_t;

   localparam digit_t BCD_MAX_DIGIT = 4'd9;

   // Result is {carry_out, sum_digit}. Non-BCD inputs give a don't-care result.
   function automatic logic [4:0] bcd_digit_add(input digit_t x, input digit_t y,
                                                input logic cin);
      logic [4:0] t;
      logic [4:0] adj;
      t   = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
      adj = t + 5'd6;
      if (t > 5'd9) begin
         return {1'b1, adj[3:0]};
      end else begin
         return {1'b0, t[3:0]};
      end
   endfunction

   // Lookup product of two digits, returned as {tens, units}.
   function automatic logic [7:0] digit_mul(input digit_t x, input digit_t y);
      logic [7:0] pr;
      logic [7:0] q;
      logic [7:0] r;
      pr = {4'h0, x} * {4'h0, y};
      q  = pr / 8'd10;
      r  = pr % 8'd10;
      return {q[3:0], r[3:0]};
   endfunction

endpackage

// File: rtl/bcd_row_mul.sv
// ---------------------------------------------------------------------------
// bcd_row_mul
// Combinational N-digit x 1-digit packed-BCD multiplier.
//   a_i   [N*4-1:0]     multiplicand, digit 0 in bits [3:0]
//   d_i   [3:0]         multiplier digit
//   row_o [(N+1)*4-1:0] product, N+1 digits
// ---------------------------------------------------------------------------
module bcd_row_mul
   import bcd_pkg::*;
#(
   parameter int unsigned N = 16
) (
   input  logic [N*4-1:0]     a_i,
   input  digit_t             d_i,
   output logic [(N+1)*4-1:0] row_o
);

   // Units digit of a_i[i]*d stays at position i, tens digit moves to i+1.
   logic [N:0][3:0] lo_w;
   logic [N:0][3:0] hi_w;

   always_comb begin : lut
      logic [7:0] pp;
      lo_w = '0;
      hi_w = '0;
      pp   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         pp          = digit_mul(a_i[i*4 +: 4], d_i);
         lo_w[i]     = pp[3:0];
         hi_w[i + 1] = pp[7:4];
      end
   end

   // Each position sums at most 9 + 8 + 1, so a single-digit carry ripples;
   // the top position cannot carry out for legal digits.
   always_comb begin : ripple
      logic       c;
      logic [4:0] s;
      c     = 1'b0;
      s     = '0;
      row_o = '0;
      for (int unsigned i = 0; i <= N; i++) begin
         s                = bcd_digit_add(lo_w[i], hi_w[i], c);
         row_o[i*4 +: 4]  = s[3:0];
         c                = s[4];
      end
   end

endmodule

// File: rtl/bcd_mul_seq.sv
// ---------------------------------------------------------------------------
// bcd_mul_seq
// Digit-serial N-digit packed-BCD multiplier: one multiplier digit per cycle,
// 2N-digit product after N steps.
//   clk, rst       clock, synchronous active-high reset
//   in_valid/in_ready    operand handshake (ready only in IDLE)
//   a, b [N*4-1:0]       packed-BCD operands
//   out_valid/out_ready  product handshake (valid held until accepted)
//   p [2N*4-1:0]         packed-BCD product, zero unless out_valid and !inv
//   inv                  some operand nibble exceeded 9 (qualified by out_valid)
// ---------------------------------------------------------------------------
module bcd_mul_seq
   import bcd_pkg::*;
#(
   parameter int unsigned N = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N*4-1:0]     a,
   input  logic [N*4-1:0]     b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*N*4-1:0]   p,
   output logic               inv
);

   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   state_e               state_q;
   logic [N*4-1:0]       areg_q;
   logic [N*4-1:0]       breg_q;
   logic [2*N*4-1:0]     acc_q;
   logic [2*N*4-1:0]     acc_d;
   logic [CW-1:0]        cnt_q;
   logic                 inv_q;
   logic [(N+1)*4-1:0]   row_w;
   logic [(N+1)*4-1:0]   upper_w;
   logic [(N+1)*4-1:0]   sum_w;
   logic                 in_bad_w;

   bcd_row_mul #(.N(N)) u_row (
      .a_i   (areg_q),
      .d_i   (breg_q[3:0]),
      .row_o (row_w)
   );

   // Upper half of the accumulator plus the new row. Partial products stay
   // below 10^(N+1), so the final carry is always zero and is dropped.
   always_comb begin : acc_add
      logic       c;
      logic [4:0] s;
      c       = 1'b0;
      s       = '0;
      sum_w   = '0;
      upper_w = {4'h0, acc_q[2*N*4-1 : N*4]};
      for (int unsigned i = 0; i <= N; i++) begin
         s                = bcd_digit_add(upper_w[i*4 +: 4], row_w[i*4 +: 4], c);
         sum_w[i*4 +: 4]  = s[3:0];
         c                = s[4];
      end
      // Shift right one digit: old digit 0 is always zero here and is dropped.
      acc_d = {sum_w, acc_q[N*4-1 : 4]};
   end

   always_comb begin : nibble_check
      in_bad_w = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if ((a[i*4 +: 4] > BCD_MAX_DIGIT) || (b[i*4 +: 4] > BCD_MAX_DIGIT)) begin
            in_bad_w = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         areg_q  <= '0;
         breg_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         inv_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  areg_q  <= a;
                  breg_q  <= b;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  inv_q   <= in_bad_w;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               acc_q  <= acc_d;
               breg_q <= {4'h0, breg_q[N*4-1 : 4]};
               if (cnt_q == CW'(N - 1)) begin
                  cnt_q   <= '0;
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign p         = (out_valid && !inv_q) ? acc_q : '0;
   assign inv       = out_valid & inv_q;

endmodule

// File: tb/tb_bcd_mul_seq.sv
module tb_bcd_mul_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // N=4 instance
   logic         rst4, iv4, rdy4, ov4, ordy4, inv4;
   logic [15:0]  a4, b4;
   logic [31:0]  p4;
   // N=16 instance
   logic         rst16, iv16, rdy16, ov16, ordy16, inv16;
   logic [63:0]  a16, b16;
   logic [127:0] p16;

   bcd_mul_seq #(.N(4)) u_dut4 (
      .clk(clk), .rst(rst4), .in_valid(iv4), .in_ready(rdy4), .a(a4), .b(b4),
      .out_valid(ov4), .out_ready(ordy4), .p(p4), .inv(inv4)
   );

   bcd_mul_seq #(.N(16)) u_dut16 (
      .clk(clk), .rst(rst16), .in_valid(iv16), .in_ready(rdy16), .a(a16), .b(b16),
      .out_valid(ov16), .out_ready(ordy16), .p(p16), .inv(inv16)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [127:0] last_p;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] p;
      logic        inv;
   } vec_t;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference: decimal long multiplication on integer digit arrays.
   task automatic ref_mul(input logic [63:0] a, input logic [63:0] b, input int n,
                          output logic [127:0] p, output logic inv);
      int ad[16];
      int bd[16];
      int acc[32];
      int carry;
      int t;
      inv = 1'b0;
      p   = '0;
      for (int i = 0; i < 32; i++) acc[i] = 0;
      for (int i = 0; i < n; i++) begin
         ad[i] = int'(a[i*4 +: 4]);
         bd[i] = int'(b[i*4 +: 4]);
         if (ad[i] > 9 || bd[i] > 9) inv = 1'b1;
      end
      for (int i = 0; i < n; i++)
         for (int j = 0; j < n; j++)
            acc[i+j] += ad[i] * bd[j];
      carry = 0;
      for (int k = 0; k < 2*n; k++) begin
         t = acc[k] + carry;
         p[k*4 +: 4] = 4'(t % 10);
         carry = t / 10;
      end
      if (inv) p = '0;
   endtask

   function automatic logic [63:0] rand_bcd(input int n);
      logic [63:0] r;
      int d;
      r = '0;
      for (int i = 0; i < n; i++) begin
         d = int'($urandom_range(0, 9));
         if ($urandom_range(0, 24) == 0) d = int'($urandom_range(10, 15));
         r[i*4 +: 4] = 4'(d);
      end
      return r;
   endfunction

   // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
   task automatic start_op(input bit big, input logic [63:0] a, input logic [63:0] b);
      int w;
      logic r;
      w = 0;
      r = big ? rdy16 : rdy4;
      while (!r && w < 40) begin
         @(negedge clk);
         w++;
         r = big ? rdy16 : rdy4;
      end
      chk("accept_ready", {127'b0, r}, 128'd1);
      if (big) begin a16 = a; b16 = b; iv16 = 1'b1; end
      else     begin a4 = a[15:0]; b4 = b[15:0]; iv4 = 1'b1; end
      @(posedge clk);
      @(negedge clk);
      iv4  = 1'b0;
      iv16 = 1'b0;
   endtask

   // lat = number of edges after the accept edge until out_valid is seen.
   task automatic wait_done(input bit big, output int lat);
      logic v;
      lat = 0;
      v = big ? ov16 : ov4;
      while (!v && lat < 60) begin
         @(negedge clk);
         lat++;
         v = big ? ov16 : ov4;
      end
   endtask

   task automatic run_op(input bit big, input logic [63:0] a, input logic [63:0] b,
                         input logic [127:0] ep, input logic ei, input string name);
      int lat;
      logic [127:0] ap;
      logic ai;
      start_op(big, a, b);
      wait_done(big, lat);
      ap = big ? p16 : {96'b0, p4};
      ai = big ? inv16 : inv4;
      last_p = ap;
      chk({name, "_latency"}, 128'(lat), big ? 128'd16 : 128'd4);
      chk({name, "_p"}, ap, ep);
      chk({name, "_inv"}, {127'b0, ai}, {127'b0, ei});
      @(negedge clk);
   endtask

   initial begin
      vec_t vecs[6];
      logic [127:0] ep;
      logic ei;
      int lat;

      vecs[0] = '{16'h1234, 16'h5678, 32'h07006652, 1'b0};
      vecs[1] = '{16'h9999, 16'h9999, 32'h99980001, 1'b0};
      vecs[2] = '{16'h0000, 16'h9999, 32'h00000000, 1'b0};
      vecs[3] = '{16'h0025, 16'h0018, 32'h00000450, 1'b0};
      vecs[4] = '{16'h12A4, 16'h0002, 32'h00000000, 1'b1};
      vecs[5] = '{16'h0003, 16'h0007, 32'h00000021, 1'b0};

      rst4 = 1'b1; rst16 = 1'b1; iv4 = 1'b0; iv16 = 1'b0;
      a4 = '0; b4 = '0; a16 = '0; b16 = '0; ordy4 = 1'b1; ordy16 = 1'b1;
      last_p = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst4 = 1'b0; rst16 = 1'b0;

      // Reset state held for 10 cycles with no input activity
      for (int c = 0; c < 10; c++) begin
         chk("rst_in_ready", {127'b0, rdy4}, 128'd1);
         chk("rst_out_valid", {127'b0, ov4}, 128'd0);
         chk("rst_p", {96'b0, p4}, 128'd0);
         chk("rst_inv", {127'b0, inv4}, 128'd0);
         @(negedge clk);
      end

      // Table-driven vectors
      for (int i = 0; i < 6; i++)
         run_op(1'b0, {48'b0, vecs[i].a}, {48'b0, vecs[i].b},
                {96'b0, vecs[i].p}, vecs[i].inv, $sformatf("vec%0d", i));

      // Backpressure: product held, new operands ignored
      ordy4 = 1'b0;
      start_op(1'b0, 64'h1234, 64'h5678);
      wait_done(1'b0, lat);
      chk("bp_latency", 128'(lat), 128'd4);
      for (int c = 0; c < 7; c++) begin
         chk("bp_p", {96'b0, p4}, 128'h07006652);
         chk("bp_in_ready", {127'b0, rdy4}, 128'd0);
         chk("bp_out_valid", {127'b0, ov4}, 128'd1);
         if (c == 1) begin a4 = 16'h1111; b4 = 16'h1111; iv4 = 1'b1; end
         @(negedge clk);
      end
      iv4 = 1'b0;
      ordy4 = 1'b1;
      @(negedge clk);
      chk("bp_release_in_ready", {127'b0, rdy4}, 128'd1);
      chk("bp_release_out_valid", {127'b0, ov4}, 128'd0);
      run_op(1'b0, 64'h0025, 64'h0018, 128'h450, 1'b0, "bp_after");

      // Reset during step 2, N=4
      start_op(1'b0, 64'h9999, 64'h9999);
      @(negedge clk);
      rst4 = 1'b1;
      @(negedge clk);
      rst4 = 1'b0;
      chk("midrst_in_ready", {127'b0, rdy4}, 128'd1);
      chk("midrst_out_valid", {127'b0, ov4}, 128'd0);
      chk("midrst_p", {96'b0, p4}, 128'd0);
      run_op(1'b0, 64'h0003, 64'h0007, 128'h21, 1'b0, "midrst_after");

      // Reset during step 2, N=16, then all-nines operands
      start_op(1'b1, 64'h9999999999999999, 64'h9999999999999999);
      @(negedge clk);
      rst16 = 1'b1;
      @(negedge clk);
      rst16 = 1'b0;
      chk("midrst16_in_ready", {127'b0, rdy16}, 128'd1);
      chk("midrst16_out_valid", {127'b0, ov16}, 128'd0);
      chk("midrst16_p", p16, 128'd0);
      ref_mul(64'h9999999999999999, 64'h9999999999999999, 16, ep, ei);
      run_op(1'b1, 64'h9999999999999999, 64'h9999999999999999, ep, ei, "n16_nines");
      chk("n16_nines_const", last_p, 128'h99999999999999980000000000000001);

      // Randomized against the reference model
      for (int i = 0; i < 30; i++) begin
         logic [63:0] ra, rb;
         ra = rand_bcd(4);
         rb = rand_bcd(4);
         ref_mul(ra, rb, 4, ep, ei);
         run_op(1'b0, ra, rb, ep, ei, $sformatf("rnd4_%0d", i));
      end
      for (int i = 0; i < 10; i++) begin
         logic [63:0] ra, rb;
         ra = rand_bcd(16);
         rb = rand_bcd(16);
         ref_mul(ra, rb, 16, ep, ei);
         run_op(1'b1, ra, rb, ep, ei, $sformatf("rnd16_%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
